// File: rtl/psum_omux_arbiter.sv
// Round-robin output-mux arbiter for router chain heads.
// Grants one port per cycle into a 2-entry output buffer.
module psum_omux_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N*40-1:0]  psum_i,
    input  logic [N-1:0]     psum_valid_i,
    output logic [N-1:0]     stall_o,
    input  logic [N-1:0]     port_en_i,
    output logic [39:0]      out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic             clear_cnt_i,
    output logic [31:0]      beat_cnt_o,
    output logic             idle_o
);

    localparam int W = 40;

    logic [N-1:0]        req;
    logic [N-1:0]        gnt;
    logic                accept;
    logic                found;
    logic                push;
    logic                pop;
    logic [PW-1:0]       gnt_idx;
    logic [PW:0]         scan;
    logic [PW:0]         nxt;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [1:0][W-1:0]   buf_q, buf_d;
    logic [W-1:0]        push_word;
    logic [31:0]         beat_q, beat_d;

    assign req    = psum_valid_i & port_en_i;
    // Accept looks only at registered occupancy: no ready-to-stall path.
    assign accept = (count_q < 2'd2);
    assign pop    = (count_q != 2'd0) & out_ready_i;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int i = 0; i < N; i++) begin
            scan = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (scan >= (PW+1)'(N)) begin
                scan = scan - (PW+1)'(N);
            end
            if (!found && req[scan[PW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        gnt  = '0;
        push = accept & found;
        if (push) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        push_word = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                push_word = psum_i[k*W +: W];
            end
        end
    end

    always_comb begin
        nxt = {1'b0, gnt_idx} + (PW+1)'(1);
        if (nxt >= (PW+1)'(N)) begin
            nxt = '0;
        end
        rr_ptr_d = push ? nxt[PW-1:0] : rr_ptr_q;
    end

    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    buf_d[0] = push_word;
                    count_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    buf_d[0] = push_word;
                end else if (push) begin
                    buf_d[1] = push_word;
                    count_d  = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    buf_d[0] = buf_q[1];
                    count_d  = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_comb begin
        beat_d = beat_q;
        if (clear_cnt_i) begin
            beat_d = '0;
        end else if (pop) begin
            beat_d = beat_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
            buf_q    <= '0;
            beat_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            buf_q    <= buf_d;
            beat_q   <= beat_d;
        end
    end

    assign stall_o     = psum_valid_i & ~gnt;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = buf_q[0];
    assign beat_cnt_o  = beat_q;
    assign idle_o      = (count_q == 2'd0) & ~|req;

endmodule

// File: tb/tb_psum_omux_arbiter.sv
// Randomized bench for psum_omux_arbiter against a queue-based model.
// Directed scenarios pin the model with literal expectations.
module tb_psum_omux_arbiter;

    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N*40-1:0] psum_i;
    logic [N-1:0]    psum_valid_i;
    logic [N-1:0]    stall_o;
    logic [N-1:0]    port_en_i;
    logic [39:0]     out_data_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic            clear_cnt_i;
    logic [31:0]     beat_cnt_o;
    logic            idle_o;

    psum_omux_arbiter #(.N(N)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .psum_i       (psum_i),
        .psum_valid_i (psum_valid_i),
        .stall_o      (stall_o),
        .port_en_i    (port_en_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .clear_cnt_i  (clear_cnt_i),
        .beat_cnt_o   (beat_cnt_o),
        .idle_o       (idle_o)
    );

    always #5 clock = ~clock;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    logic [39:0]  mq[$];
    int           rr;
    logic [31:0]  mbeat;
    logic [N-1:0] mstall;
    int           g;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic int model_grant();
        if (mq.size() >= 2) return -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (rr + i) % N;
            if (psum_valid_i[k] && port_en_i[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [39:0] word(input int k);
        return psum_i[k*40 +: 40];
    endfunction

    function automatic logic [39:0] rword();
        return {8'($urandom), 32'($urandom)};
    endfunction

    // Compare all outputs against the model at mid-cycle.
    task automatic mid();
        logic [N-1:0] es;
        #4;
        g  = model_grant();
        es = psum_valid_i;
        if (g >= 0) es[g] = 1'b0;
        chk("stall", 64'(stall_o), 64'(es));
        chk("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", 64'(out_data_o), 64'(mq[0]));
        chk("beat", 64'(beat_cnt_o), 64'(mbeat));
        chk("idle", 64'(idle_o),
            64'(mq.size() == 0 && (psum_valid_i & port_en_i) == '0));
        mstall = es;
    endtask

    // Advance the model across the rising edge.
    task automatic edge_step();
        logic        pop;
        logic [39:0] w;
        pop = (mq.size() != 0) && out_ready_i;
        w   = (g >= 0) ? word(g) : '0;
        @(posedge clock);
        if (pop) void'(mq.pop_front());
        if (clear_cnt_i) mbeat = '0;
        else if (pop) mbeat = mbeat + 32'd1;
        if (g >= 0) begin
            mq.push_back(w);
            rr = (g + 1) % N;
        end
        #1;
    endtask

    // Replace words on ports that are not holding a stalled word.
    task automatic refresh_words();
        for (int k = 0; k < N; k++)
            if (!(psum_valid_i[k] && mstall[k])) psum_i[k*40 +: 40] = rword();
    endtask

    task automatic drain(input int cyc);
        psum_valid_i = '0;
        out_ready_i  = 1'b1;
        for (int i = 0; i < cyc; i++) begin
            mid();
            edge_step();
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rr     = 0;
        mbeat  = '0;
        mstall = '0;
        g      = -1;
    endtask

    initial begin
        logic [39:0] w0;
        logic [31:0] b0;
        logic [N-1:0] exp_s;
        reset_n      = 1'b0;
        psum_i       = '0;
        psum_valid_i = '0;
        port_en_i    = 4'b1111;
        out_ready_i  = 1'b1;
        clear_cnt_i  = 1'b0;
        model_reset();
        #2;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_data", 64'(out_data_o), 64'd0);
        chk("rst_beat", 64'(beat_cnt_o), 64'd0);
        chk("rst_idle", 64'(idle_o), 64'd1);
        #10;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single port: port 2 presents one word.
        psum_i[2*40 +: 40] = 40'h053F800000;
        psum_valid_i       = 4'b0100;
        mid();
        chk("single_stall", 64'(stall_o), 64'd0);
        edge_step();
        psum_valid_i = '0;
        mid();
        chk("single_data", 64'(out_data_o), 64'h053F800000);
        chk("single_valid", 64'(out_valid_o), 64'd1);
        edge_step();
        mid();
        chk("single_beat", 64'(beat_cnt_o), 64'd1);
        edge_step();

        // Pointer sits at 3 after granting port 2; then full contention.
        for (int k = 0; k < N; k++) psum_i[k*40 +: 40] = rword();
        psum_valid_i = 4'b1111;
        mid();
        chk("rr_after_single", 64'(stall_o), 64'(4'b0111));
        edge_step();
        b0 = beat_cnt_o;
        for (int i = 0; i < 8; i++) begin
            refresh_words();
            mid();
            exp_s = 4'b1111;
            exp_s[i % 4] = 1'b0;
            chk("contention_order", 64'(stall_o), 64'(exp_s));
            edge_step();
        end
        chk("contention_8_words", 64'(beat_cnt_o - b0), 64'd8);
        drain(3);

        // Back-pressure with ports 0 and 1.
        out_ready_i  = 1'b0;
        psum_i[0 +: 40]  = rword();
        psum_i[40 +: 40] = rword();
        psum_valid_i = 4'b0011;
        w0 = psum_i[0 +: 40];
        mid();
        edge_step();
        refresh_words();
        mid();
        edge_step();
        for (int i = 0; i < 4; i++) begin
            refresh_words();
            mid();
            chk("bp_stall", 64'(stall_o), 64'(4'b0011));
            edge_step();
        end
        out_ready_i = 1'b1;
        mid();
        chk("bp_first_out", 64'(out_data_o), 64'(w0));
        edge_step();
        for (int i = 0; i < 6; i++) begin
            refresh_words();
            mid();
            edge_step();
        end
        drain(3);

        // Enable mask holds port 2 off.
        port_en_i    = 4'b1011;
        psum_i[2*40 +: 40] = rword();
        psum_valid_i = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("mask_stall", 64'(stall_o), 64'(4'b0100));
            chk("mask_noout", 64'(out_valid_o), 64'd0);
            edge_step();
        end
        port_en_i = 4'b1111;
        mid();
        chk("mask_release", 64'(stall_o), 64'd0);
        edge_step();
        drain(2);

        // Push+pop at count 1, then clear during a pop.
        psum_valid_i = 4'b0001;
        psum_i[0 +: 40] = rword();
        mid();
        edge_step();
        psum_i[0 +: 40] = rword();
        w0 = psum_i[0 +: 40];
        mid();
        edge_step();
        psum_valid_i = '0;
        mid();
        chk("pushpop_data", 64'(out_data_o), 64'(w0));
        chk("pushpop_valid", 64'(out_valid_o), 64'd1);
        clear_cnt_i = 1'b1;
        edge_step();
        clear_cnt_i = 1'b0;
        mid();
        chk("clear_beat", 64'(beat_cnt_o), 64'd0);
        edge_step();

        // Async reset with two buffered words.
        out_ready_i  = 1'b0;
        psum_valid_i = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            refresh_words();
            mid();
            edge_step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid_o), 64'd0);
        chk("arst_beat", 64'(beat_cnt_o), 64'd0);
        model_reset();
        psum_valid_i = '0;
        out_ready_i  = 1'b1;
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        psum_valid_i = 4'b1111;
        for (int k = 0; k < N; k++) psum_i[k*40 +: 40] = rword();
        mid();
        chk("arst_grant0", 64'(stall_o), 64'(4'b1110));
        edge_step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(psum_valid_i[k] && mstall[k])) begin
                    psum_valid_i[k] = ($urandom_range(0, 99) < 55);
                    psum_i[k*40 +: 40] = rword();
                end
            end
            if ($urandom_range(0, 19) == 0) port_en_i = 4'($urandom);
            else if ($urandom_range(0, 9) == 0) port_en_i = 4'b1111;
            out_ready_i = ($urandom_range(0, 99) < 65);
            clear_cnt_i = ($urandom_range(0, 99) < 3);
            mid();
            edge_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
